// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: write, reserve, clear-control and read-port signals.
// master: producer side (datapath / testbench); slave: the register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                       RegWrite;
  logic [ADDR_W-1:0]          WriteReg;
  logic [DATA_W-1:0]          WriteData;
  logic [NUM_RD*ADDR_W-1:0]   ReadReg;
  logic [NUM_RD*DATA_W-1:0]   ReadData;
  logic [NUM_RD-1:0]          Pending;
  logic                       Reserve;
  logic [ADDR_W-1:0]          ReserveReg;
  logic                       ClearReq;
  logic                       ClearBusy;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg, Reserve, ReserveReg, ClearReq,
    input  ReadData, Pending, ClearBusy
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg, Reserve, ReserveReg, ClearReq,
    output ReadData, Pending, ClearBusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with 1-cycle registered reads, same-cycle write
// forwarding, a per-register pending scoreboard and a sequenced bulk-clear engine.
// Ports:
//   clk   - clock, all state updates on posedge
//   rst   - asynchronous active-low reset
//   bus   - regfile_mp_if.slave: RegWrite/WriteReg/WriteData (write), ReadReg/ReadData/
//           Pending (NUM_RD read ports), Reserve/ReserveReg (scoreboard set),
//           ClearReq/ClearBusy (bulk clear)
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_if.slave    bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         pend_q, pend_d;
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_RD-1:0]        rpend_q, rpend_d;

  logic wr_en_c, rs_en_c, clr_en_c;

  // Effective write/reserve only while idle and not targeting a hardwired zero register
  always_comb begin
    clr_en_c = (state_q == CLEAR);
    wr_en_c  = bus.RegWrite && (state_q == IDLE) && !(ZERO_EN && (bus.WriteReg == '0));
    rs_en_c  = bus.Reserve  && (state_q == IDLE) && !(ZERO_EN && (bus.ReserveReg == '0));
  end

  // Bulk-clear sequencer: walks the counter once over all entries
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ClearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Scoreboard next state; reserve after write so a new producer keeps the bit set
  always_comb begin
    pend_d = pend_q;
    if (clr_en_c) pend_d[cnt_q] = 1'b0;
    if (wr_en_c)  pend_d[bus.WriteReg] = 1'b0;
    if (rs_en_c)  pend_d[bus.ReserveReg] = 1'b1;
  end

  // Read ports: forward same-cycle write data, report post-edge pending state
  always_comb begin
    rdata_d = '0;
    rpend_d = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      ra = bus.ReadReg[p*ADDR_W +: ADDR_W];
      if (ZERO_EN && (ra == '0))
        rdata_d[p*DATA_W +: DATA_W] = '0;
      else if (wr_en_c && (bus.WriteReg == ra))
        rdata_d[p*DATA_W +: DATA_W] = bus.WriteData;
      else
        rdata_d[p*DATA_W +: DATA_W] = mem_q[ra];
      rpend_d[p] = pend_d[ra];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      rdata_q <= '0;
      rpend_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      rpend_q <= rpend_d;
      if (clr_en_c) mem_q[cnt_q] <= '0;
      if (wr_en_c)  mem_q[bus.WriteReg] <= bus.WriteData;
    end
  end

  assign bus.ReadData  = rdata_q;
  assign bus.Pending   = rpend_q;
  assign bus.ClearBusy = busy_q;

endmodule
